// File: rtl/turnstile_credit_driver_pkg.sv
// Shared definitions for the turnstile credit driver: FSM state encoding used by
// the RTL and by anything that needs to observe the entry sequencer.
package turnstile_credit_driver_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_COIN  = 3'd1,
    ST_OPEN  = 3'd2,
    ST_PASS  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage : turnstile_credit_driver_pkg

// File: rtl/turnstile_credit_driver_if.sv
// Command/status channel between the credit driver and the turnstile controller.
// The master modport is the driver side; the slave modport is the turnstile side.
interface turnstile_credit_driver_if #(
  parameter int CREDIT_WIDTH = 4
);

  logic                    coin;
  logic                    push;
  logic                    locked;
  logic                    pass_pulse;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    credit_full;

  modport master (
    output coin,
    output push,
    output pass_pulse,
    output credits,
    output credit_full,
    input  locked
  );

  modport slave (
    input  coin,
    input  push,
    input  pass_pulse,
    input  credits,
    input  credit_full,
    output locked
  );

endinterface : turnstile_credit_driver_if

// File: rtl/turnstile_debounce.sv
// Two-flop synchronizer followed by a stability counter; the clean output only
// follows the raw input after DEBOUNCE_LIMIT consecutive differing cycles.
module turnstile_debounce #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             clean_q;
  logic             clean_d;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync2_q == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      clean_d = ~clean_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let all flops sample the pre-edge values,
      // which is what makes sync1_q -> sync2_q a real two-stage chain.
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean_o = clean_q;

endmodule : turnstile_debounce

// File: rtl/turnstile_credit_driver.sv
// Conditions coin/push sensors, counts paid credits and sequences one entry at a
// time through the turnstile, consuming a credit when the turnstile relocks.
module turnstile_credit_driver
  import turnstile_credit_driver_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CREDIT_WIDTH   = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset_L,
  input  logic                    i_Coin_Raw,
  input  logic                    i_Push_Raw,
  input  logic                    i_Locked,
  output logic                    o_Coin,
  output logic                    o_Push,
  output logic [CREDIT_WIDTH-1:0] o_Credits,
  output logic                    o_Credit_Full,
  output logic                    o_Pass_Pulse
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = {CREDIT_WIDTH{1'b1}};

  logic coin_deb;
  logic push_deb;
  logic coin_deb_prev_q;
  logic coin_rise;
  logic credit_dec;

  logic [CREDIT_WIDTH-1:0] credits_q;
  logic [CREDIT_WIDTH-1:0] credits_d;

  state_e state_q;
  state_e state_d;
  logic   coin_q, coin_d;
  logic   push_q, push_d;
  logic   pass_q, pass_d;

  turnstile_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_coin_debounce (
    .clk     (i_Clk),
    .rst_n   (i_Reset_L),
    .raw_i   (i_Coin_Raw),
    .clean_o (coin_deb)
  );

  turnstile_debounce #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_push_debounce (
    .clk     (i_Clk),
    .rst_n   (i_Reset_L),
    .raw_i   (i_Push_Raw),
    .clean_o (push_deb)
  );

  assign coin_rise  = coin_deb & ~coin_deb_prev_q;
  assign credit_dec = (state_q == ST_PASS) && (credits_q != '0);

  // A coin landing on the PASS cycle cancels the decrement; at full, lone coins are dropped.
  always_comb begin
    credits_d = credits_q;
    if (coin_rise && !credit_dec) begin
      if (credits_q != CREDIT_MAX) credits_d = credits_q + CREDIT_WIDTH'(1);
    end else if (credit_dec && !coin_rise) begin
      credits_d = credits_q - CREDIT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (credits_q != '0) state_d = ST_COIN;
      ST_COIN:  if (!i_Locked)       state_d = ST_OPEN;
      ST_OPEN:  if (i_Locked)        state_d = ST_PASS;
      ST_PASS:                       state_d = ST_DRAIN;
      // Holding here until the arm is released stops one long push spending two credits.
      ST_DRAIN: if (!push_deb)       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
    // Outputs are decoded from the next state so they register alongside state_q.
    coin_d = (state_d == ST_COIN);
    push_d = (state_d == ST_OPEN) && push_deb;
    pass_d = (state_d == ST_PASS);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_L) begin
    if (!i_Reset_L) begin
      state_q         <= ST_IDLE;
      coin_q          <= 1'b0;
      push_q          <= 1'b0;
      pass_q          <= 1'b0;
      credits_q       <= '0;
      coin_deb_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      coin_q          <= coin_d;
      push_q          <= push_d;
      pass_q          <= pass_d;
      credits_q       <= credits_d;
      coin_deb_prev_q <= coin_deb;
    end
  end

  assign o_Coin        = coin_q;
  assign o_Push        = push_q;
  assign o_Pass_Pulse  = pass_q;
  assign o_Credits     = credits_q;
  assign o_Credit_Full = (credits_q == CREDIT_MAX);

endmodule : turnstile_credit_driver

// File: tb/tb_turnstile_credit_driver.sv
// Bench for turnstile_credit_driver with a behavioural turnstile controller
// closing the i_Locked loop and a credit scoreboard.
module tb_turnstile_credit_driver;
  import turnstile_credit_driver_pkg::*;

  localparam int DL   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic coin_raw = 1'b0;
  logic push_raw = 1'b0;

  turnstile_credit_driver_if #(.CREDIT_WIDTH(CW)) tif ();

  turnstile_credit_driver #(.DEBOUNCE_LIMIT(DL), .CREDIT_WIDTH(CW)) dut (
    .i_Clk         (clk),
    .i_Reset_L     (rst_n),
    .i_Coin_Raw    (coin_raw),
    .i_Push_Raw    (push_raw),
    .i_Locked      (tif.locked),
    .o_Coin        (tif.coin),
    .o_Push        (tif.push),
    .o_Credits     (tif.credits),
    .o_Credit_Full (tif.credit_full),
    .o_Pass_Pulse  (tif.pass_pulse)
  );

  always #5 clk = ~clk;

  // Turnstile controller: a coin unlocks it, a push while unlocked relocks it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        tif.locked <= 1'b1;
    else if (tif.locked && tif.coin)   tif.locked <= 1'b0;
    else if (!tif.locked && tif.push)  tif.locked <= 1'b1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every expected o_Credits change is queued when stimulus is applied.
  int      exp_q[$];
  int      model_credits = 0;
  logic [CW-1:0] last_credits = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_credits <= tif.credits;
    end else if (tif.credits != last_credits) begin
      if (exp_q.size() == 0) check("credit_unexpected", 32'(tif.credits), 32'(last_credits));
      else                   check("credit_sb", 32'(tif.credits), 32'(exp_q.pop_front()));
      last_credits <= tif.credits;
    end
  end

  int   pass_count  = 0;
  logic pass_prev   = 1'b0;
  logic pass_double = 1'b0;

  always @(negedge clk) begin
    pass_prev <= tif.pass_pulse;
    if (tif.pass_pulse && pass_prev) pass_double <= 1'b1;
    if (tif.pass_pulse) pass_count <= pass_count + 1;
  end

  task automatic wait_state(input state_e s, input int budget, input string tag);
    int n = 0;
    while (dut.state_q != s && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  task automatic coin_clean();
    if (model_credits < CMAX) begin
      model_credits++;
      exp_q.push_back(model_credits);
    end
    coin_raw = 1'b1;
    repeat (8) tick();
    coin_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic push_entry();
    model_credits--;
    exp_q.push_back(model_credits);
    push_raw = 1'b1;
    repeat (8) tick();
    push_raw = 1'b0;
    repeat (16) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic any;
    int   n;
    int   pass_base;

    // 1: reset held with toggling inputs
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      coin_raw = 1'($urandom_range(1));
      push_raw = 1'($urandom_range(1));
      tick();
      any |= tif.coin | tif.push | tif.pass_pulse | tif.credit_full | (|tif.credits);
    end
    check("t1_outputs_in_reset", 32'(any), 32'd0);
    coin_raw = 1'b0;
    push_raw = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("t1_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("t1_credits_zero", 32'(tif.credits), 32'd0);
    repeat (10) tick();

    // 2: one clean coin, then one clean push
    coin_raw      = 1'b1;
    model_credits = 1;
    exp_q.push_back(1);
    repeat (6) tick();
    check("t2_credit_before_7", 32'(tif.credits), 32'd0);
    tick();
    check("t2_credit_at_7", 32'(tif.credits), 32'd1);
    tick();
    check("t2_coin_asserted", 32'(tif.coin), 32'd1);
    tick();
    check("t2_coin_held", 32'(tif.coin), 32'd1);
    check("t2_unlocked", 32'(tif.locked), 32'd0);
    tick();
    check("t2_state_open", 32'(dut.state_q), 32'(ST_OPEN));
    check("t2_coin_dropped", 32'(tif.coin), 32'd0);
    repeat (10) tick();
    coin_raw = 1'b0;
    repeat (10) tick();
    push_raw      = 1'b1;
    model_credits = 0;
    exp_q.push_back(0);
    n = 0;
    while (!tif.push && n < 20) begin tick(); n++; end
    check("t2_push_forwarded", 32'(tif.push), 32'd1);
    check("t2_push_in_open", 32'(dut.state_q), 32'(ST_OPEN));
    n = 0;
    while (!tif.locked && n < 10) begin tick(); n++; end
    check("t2_relocked", 32'(tif.locked), 32'd1);
    check("t2_no_pass_yet", 32'(tif.pass_pulse), 32'd0);
    tick();
    check("t2_pass_pulse", 32'(tif.pass_pulse), 32'd1);
    tick();
    check("t2_pass_single", 32'(tif.pass_pulse), 32'd0);
    check("t2_credits_after", 32'(tif.credits), 32'd0);
    check("t2_state_drain", 32'(dut.state_q), 32'(ST_DRAIN));
    repeat (12) tick();
    push_raw = 1'b0;
    wait_state(ST_IDLE, 30, "t2_back_to_idle");

    // 3: sub-threshold glitches
    any = 1'b0;
    coin_raw = 1'b1;
    repeat (3) tick();
    coin_raw = 1'b0;
    repeat (12) tick();
    push_raw = 1'b1;
    repeat (3) tick();
    push_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      any |= tif.coin | tif.push | (|tif.credits);
    end
    check("t3_glitch_ignored", 32'(any), 32'd0);

    // 4: saturation, then three entries
    repeat (4) coin_clean();
    check("t4_credits_full", 32'(tif.credits), 32'(CMAX));
    check("t4_full_flag", 32'(tif.credit_full), 32'd1);
    check("t4_waiting_open", 32'(dut.state_q), 32'(ST_OPEN));
    pass_base = pass_count;
    repeat (3) push_entry();
    check("t4_pass_count", 32'(pass_count - pass_base), 32'd3);
    check("t4_credits_empty", 32'(tif.credits), 32'd0);
    check("t4_full_cleared", 32'(tif.credit_full), 32'd0);

    // 5: coin edge coinciding with PASS, then a held push
    coin_clean();
    wait_state(ST_OPEN, 40, "t5_open");
    push_raw = 1'b1;
    repeat (3) tick();
    coin_raw = 1'b1;
    n = 0;
    while (!tif.pass_pulse && n < 20) begin tick(); n++; end
    check("t5_pass_seen", 32'(tif.pass_pulse), 32'd1);
    check("t5_credit_at_pass", 32'(tif.credits), 32'd1);
    tick();
    check("t5_credit_unchanged", 32'(tif.credits), 32'd1);
    tick();
    coin_raw = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any |= tif.push | (dut.state_q != ST_DRAIN);
    end
    check("t5_drain_holds", 32'(any), 32'd0);
    push_raw = 1'b0;
    wait_state(ST_COIN, 30, "t5_next_entry");
    wait_state(ST_OPEN, 10, "t5_reopen");

    // 6: asynchronous reset mid-OPEN with two credits
    coin_clean();
    check("t6_two_credits", 32'(tif.credits), 32'd2);
    push_raw = 1'b1;
    n = 0;
    while (!tif.push && n < 20) begin tick(); n++; end
    check("t6_push_before_reset", 32'(tif.push), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_outputs", 32'({tif.coin, tif.push, tif.pass_pulse, tif.credit_full}), 32'd0);
    check("t6_async_credits", 32'(tif.credits), 32'd0);
    check("t6_async_state", 32'(dut.state_q), 32'(ST_IDLE));
    push_raw      = 1'b0;
    model_credits = 0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle_after", 32'(dut.state_q), 32'(ST_IDLE));
    check("t6_credits_after", 32'(tif.credits), 32'd0);
    repeat (5) tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("pass_never_double", 32'(pass_double), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_turnstile_credit_driver
